// File: rtl/mfe_param.sv
// mfe_param: parametrised 3x3 window filter engine (median / min / max).
// Walks an IMG_W x IMG_H raster in row-major order. For each pixel it fetches
// the nine window samples from the source port, zero-padding outside the image.
// It writes one filtered pixel to the result port every 11 cycles.
// Ports:
//   clk, reset     single clock, asynchronous active-high reset
//   ready          start request, sampled only while idle
//   mode           0/3 median, 1 minimum, 2 maximum (latched at start)
//   busy           high while a frame is being processed
//   iaddr, idata   source address / pixel (pixel valid one cycle later)
//   wen            one-cycle result write strobe
//   addr, data_wr  result address / pixel
//   data_rd        reserved, ignored
module mfe_param #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    input  logic [DW-1:0] data_rd
);

    localparam int unsigned XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned KW   = 4;
    localparam int unsigned NTAP = 9;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LAST  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // Window offset codes for one axis
    localparam logic [1:0] OFS_M1 = 2'd0;
    localparam logic [1:0] OFS_0  = 2'd1;
    localparam logic [1:0] OFS_P1 = 2'd2;

    localparam logic [XW-1:0] X_MAX      = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(IMG_H - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(NTAP - 1);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(IMG_W);

    // Control and output registers
    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_mode;
    logic          r_busy;
    logic          r_wen;
    logic [AW-1:0] r_iaddr;
    logic          r_pad;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    // Sample pipeline and sorter
    logic [DW-1:0] r_samp;
    logic          r_samp_vld;
    logic [DW-1:0] r_sort [NTAP];

    // Next-state / derived wires
    logic [1:0]    w_state_nxt;
    logic [KW-1:0] w_k_nxt;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [1:0]    w_mode_nxt;
    logic          w_busy_nxt;
    logic          w_wen_nxt;
    logic [AW-1:0] w_iaddr_nxt;
    logic          w_pad_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_data_nxt;
    logic          w_clr;

    logic [1:0]    w_dx;
    logic [1:0]    w_dy;
    logic [XW-1:0] w_sx;
    logic [YW-1:0] w_sy;
    logic          w_pad_x;
    logic          w_pad_y;
    logic [AW-1:0] w_slot_addr;
    logic [AW-1:0] w_pix_addr;

    logic [DW-1:0] w_ins [NTAP];
    logic [DW-1:0] w_result;

    logic          w_unused;

    assign w_unused   = ^data_rd;
    assign w_pix_addr = AW'(r_y) * ROW_STRIDE + AW'(r_x);

    // Frame/pixel/slot sequencing and next values of the registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_mode_nxt  = r_mode;
        w_busy_nxt  = r_busy;
        w_wen_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ready) begin
                    w_state_nxt = S_FETCH;
                    w_busy_nxt  = 1'b1;
                    w_k_nxt     = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_mode_nxt  = mode;
                    w_clr       = 1'b1;
                end
            end
            S_FETCH: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = S_LAST;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            S_LAST: begin
                w_state_nxt = S_WRITE;
                w_wen_nxt   = 1'b1;
                w_addr_nxt  = w_pix_addr;
                w_data_nxt  = w_result;
            end
            S_WRITE: begin
                w_k_nxt = '0;
                if (r_x == X_MAX) begin
                    w_x_nxt = '0;
                    if (r_y == Y_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_y_nxt     = r_y + YW'(1);
                        w_state_nxt = S_FETCH;
                        w_clr       = 1'b1;
                    end
                end else begin
                    w_x_nxt     = r_x + XW'(1);
                    w_state_nxt = S_FETCH;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address of the window slot presented next, clamped into the image;
    // clamped slots are flagged so their sample is replaced by zero
    always_comb begin
        w_dy = OFS_0;
        w_dx = OFS_0;
        case (w_k_nxt)
            4'd0: begin w_dy = OFS_M1; w_dx = OFS_M1; end
            4'd1: begin w_dy = OFS_M1; w_dx = OFS_0;  end
            4'd2: begin w_dy = OFS_M1; w_dx = OFS_P1; end
            4'd3: begin w_dy = OFS_0;  w_dx = OFS_M1; end
            4'd4: begin w_dy = OFS_0;  w_dx = OFS_0;  end
            4'd5: begin w_dy = OFS_0;  w_dx = OFS_P1; end
            4'd6: begin w_dy = OFS_P1; w_dx = OFS_M1; end
            4'd7: begin w_dy = OFS_P1; w_dx = OFS_0;  end
            4'd8: begin w_dy = OFS_P1; w_dx = OFS_P1; end
            default: begin w_dy = OFS_0; w_dx = OFS_0; end
        endcase

        w_sx    = w_x_nxt;
        w_pad_x = 1'b0;
        if (w_dx == OFS_M1) begin
            if (w_x_nxt == '0) w_pad_x = 1'b1;
            else               w_sx    = w_x_nxt - XW'(1);
        end else if (w_dx == OFS_P1) begin
            if (w_x_nxt == X_MAX) w_pad_x = 1'b1;
            else                  w_sx    = w_x_nxt + XW'(1);
        end

        w_sy    = w_y_nxt;
        w_pad_y = 1'b0;
        if (w_dy == OFS_M1) begin
            if (w_y_nxt == '0) w_pad_y = 1'b1;
            else               w_sy    = w_y_nxt - YW'(1);
        end else if (w_dy == OFS_P1) begin
            if (w_y_nxt == Y_MAX) w_pad_y = 1'b1;
            else                  w_sy    = w_y_nxt + YW'(1);
        end

        w_slot_addr = AW'(w_sy) * ROW_STRIDE + AW'(w_sx);
        w_iaddr_nxt = (w_state_nxt == S_FETCH) ? w_slot_addr : r_iaddr;
        w_pad_nxt   = (w_state_nxt == S_FETCH) ? (w_pad_x | w_pad_y) : r_pad;
    end

    // Parallel insert of r_samp into the ascending array, dropping the minimum.
    // The array starts as nine zeros; every sample is >= 0, so after nine
    // inserts exactly the nine samples remain as a multiset.
    always_comb begin
        w_ins = r_sort;
        for (int i = 0; i < NTAP - 1; i++) begin
            if (r_sort[i+1] <= r_samp)
                w_ins[i] = r_sort[i+1];
            else if (r_sort[i] <= r_samp)
                w_ins[i] = r_samp;
            else
                w_ins[i] = r_sort[i];
        end
        w_ins[NTAP-1] = (r_sort[NTAP-1] <= r_samp) ? r_samp : r_sort[NTAP-1];
    end

    // Result selection; taken from the insert network so the last sample counts
    always_comb begin
        case (r_mode)
            2'd1:    w_result = w_ins[0];
            2'd2:    w_result = w_ins[NTAP-1];
            default: w_result = w_ins[4];
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= '0;
            r_busy  <= 1'b0;
            r_wen   <= 1'b0;
            r_iaddr <= '0;
            r_pad   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_mode  <= w_mode_nxt;
            r_busy  <= w_busy_nxt;
            r_wen   <= w_wen_nxt;
            r_iaddr <= w_iaddr_nxt;
            r_pad   <= w_pad_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Capture each slot's sample at the end of its fetch cycle, insert it next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp     <= '0;
            r_samp_vld <= 1'b0;
            for (int i = 0; i < NTAP; i++) r_sort[i] <= '0;
        end else begin
            r_samp_vld <= (r_state == S_FETCH);
            if (r_state == S_FETCH) r_samp <= r_pad ? '0 : idata;
            if (w_clr) begin
                for (int i = 0; i < NTAP; i++) r_sort[i] <= '0;
            end else if (r_samp_vld) begin
                r_sort <= w_ins;
            end
        end
    end

    assign busy    = r_busy;
    assign wen     = r_wen;
    assign iaddr   = r_iaddr;
    assign addr    = r_addr;
    assign data_wr = r_data;

endmodule

// File: tb/tb_mfe_param.sv
// tb_mfe_param: self-checking bench for mfe_param.
// Instance A: 4x4, 8-bit image. Instance B: 5x3, 12-bit image.
// Expected pixels come from a behavioural 3x3 zero-padded window model.
module tb_mfe_param;

    logic clk;
    logic reset;

    logic       a_ready;
    logic [1:0] a_mode;
    logic       a_busy;
    logic [3:0] a_iaddr;
    logic [7:0] a_idata;
    logic       a_wen;
    logic [3:0] a_addr;
    logic [7:0] a_data_wr;

    logic        b_ready;
    logic [1:0]  b_mode;
    logic        b_busy;
    logic [3:0]  b_iaddr;
    logic [11:0] b_idata;
    logic        b_wen;
    logic [3:0]  b_addr;
    logic [11:0] b_data_wr;

    int a_img [16];
    int b_img [16];

    int n_checks;
    int n_pass;

    int r_cyc;
    int r_nw;
    int r_consec;
    int r_iamax;
    int r_addr [32];
    int r_data [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source ROMs: data for the presented address is stable until the next edge
    assign a_idata = 8'(a_img[a_iaddr]);
    assign b_idata = 12'(b_img[b_iaddr]);

    mfe_param #(.IMG_W(4), .IMG_H(4), .DW(8)) u_a (
        .clk     (clk),
        .reset   (reset),
        .ready   (a_ready),
        .mode    (a_mode),
        .busy    (a_busy),
        .iaddr   (a_iaddr),
        .idata   (a_idata),
        .wen     (a_wen),
        .addr    (a_addr),
        .data_wr (a_data_wr),
        .data_rd (8'h00)
    );

    mfe_param #(.IMG_W(5), .IMG_H(3), .DW(12)) u_b (
        .clk     (clk),
        .reset   (reset),
        .ready   (b_ready),
        .mode    (b_mode),
        .busy    (b_busy),
        .iaddr   (b_iaddr),
        .idata   (b_idata),
        .wen     (b_wen),
        .addr    (b_addr),
        .data_wr (b_data_wr),
        .data_rd (12'h000)
    );

    // Reference: gather the 3x3 neighbourhood (zero outside), sort, pick by mode
    function automatic int model_px(input int img[16], input int w, input int h,
                                    input int x, input int y, input int m);
        int v[9];
        int n;
        int t;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (x + dx < 0 || x + dx >= w || y + dy < 0 || y + dy >= h) v[n] = 0;
                else v[n] = img[(y + dy) * w + (x + dx)];
                n++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        case (m)
            1: return v[0];
            2: return v[8];
            default: return v[4];
        endcase
    endfunction

    // Start (or continue) one frame and record busy cycles, writes and iaddr range.
    // Called at a negedge; returns at the first negedge with busy low.
    task automatic run_frame(input bit sel_b, input logic [1:0] m, input bit keep_ready,
                             input bit pulse_busy, input bit started);
        bit prev_wen;
        bit bsy;
        bit wn;
        int ad;
        int dt;
        int ia;
        if (!started) begin
            if (sel_b) begin b_mode = m; b_ready = 1'b1; end
            else       begin a_mode = m; a_ready = 1'b1; end
            @(negedge clk);
        end
        // mode must have been latched; scramble it for the rest of the frame
        if (sel_b) begin b_mode = ~m; b_ready = keep_ready; end
        else       begin a_mode = ~m; a_ready = keep_ready; end
        r_cyc = 0; r_nw = 0; r_consec = 0; r_iamax = 0; prev_wen = 1'b0;
        while (r_cyc < 4000) begin
            bsy = sel_b ? b_busy : a_busy;
            if (!bsy) break;
            wn = sel_b ? b_wen : a_wen;
            ad = sel_b ? int'(b_addr) : int'(a_addr);
            dt = sel_b ? int'(b_data_wr) : int'(a_data_wr);
            ia = sel_b ? int'(b_iaddr) : int'(a_iaddr);
            r_cyc++;
            if (ia > r_iamax) r_iamax = ia;
            if (wn) begin
                if (r_nw < 32) begin r_addr[r_nw] = ad; r_data[r_nw] = dt; end
                r_nw++;
                if (prev_wen) r_consec++;
            end
            prev_wen = wn;
            if (pulse_busy) begin
                if (sel_b) b_ready = (r_cyc % 23 == 7);
                else       a_ready = (r_cyc % 23 == 7);
            end
            @(negedge clk);
        end
        if (!keep_ready) begin
            if (sel_b) b_ready = 1'b0; else a_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", a_wen); else n_pass++;
        n_checks++; if (a_iaddr !== 4'd0) $display("FAIL reset_iaddr: got %0d want 0", a_iaddr); else n_pass++;
        n_checks++; if (a_addr !== 4'd0) $display("FAIL reset_addr: got %0d want 0", a_addr); else n_pass++;
        n_checks++; if (a_data_wr !== 8'd0) $display("FAIL reset_data_wr: got %0h want 0", a_data_wr); else n_pass++;
        n_checks++; if (b_busy !== 1'b0 || b_wen !== 1'b0) $display("FAIL reset_b_busy_wen: got %b%b want 00", b_busy, b_wen); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Flat 0x55 image: outcome depends only on how many window taps are real
    task automatic test_const_image();
        int x;
        int y;
        bit xb;
        bit yb;
        int exp;
        for (int i = 0; i < 16; i++) a_img[i] = 'h55;
        for (int m = 0; m < 3; m++) begin
            run_frame(1'b0, 2'(m), 1'b0, 1'b0, 1'b0);
            n_checks++; if (r_cyc !== 176) $display("FAIL const_m%0d_cycles: got %0d want 176", m, r_cyc); else n_pass++;
            n_checks++; if (r_nw !== 16) $display("FAIL const_m%0d_writes: got %0d want 16", m, r_nw); else n_pass++;
            for (int i = 0; i < r_nw && i < 16; i++) begin
                x = i % 4; y = i / 4;
                xb = (x == 0 || x == 3);
                yb = (y == 0 || y == 3);
                if (m == 0)      exp = (xb && yb) ? 0 : 'h55;
                else if (m == 1) exp = (xb || yb) ? 0 : 'h55;
                else             exp = 'h55;
                n_checks++;
                if (r_addr[i] !== i || r_data[i] !== exp)
                    $display("FAIL const_m%0d_px%0d: got addr %0d data %0h want addr %0d data %0h", m, i, r_addr[i], r_data[i], i, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ramp();
        int exp;
        for (int i = 0; i < 16; i++) a_img[i] = i * 16;
        run_frame(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (r_cyc !== 176) $display("FAIL ramp_cycles: got %0d want 176", r_cyc); else n_pass++;
        n_checks++; if (r_nw !== 16) $display("FAIL ramp_writes: got %0d want 16", r_nw); else n_pass++;
        n_checks++; if (r_consec !== 0) $display("FAIL ramp_wen_consecutive: got %0d want 0", r_consec); else n_pass++;
        n_checks++; if (r_data[5] !== 80) $display("FAIL ramp_addr5: got %0d want 80", r_data[5]); else n_pass++;
        for (int i = 0; i < r_nw && i < 16; i++) begin
            exp = model_px(a_img, 4, 4, i % 4, i / 4, 0);
            n_checks++;
            if (r_addr[i] !== i || r_data[i] !== exp)
                $display("FAIL ramp_px%0d: got addr %0d data %0d want addr %0d data %0d", i, r_addr[i], r_data[i], i, exp);
            else n_pass++;
        end
    endtask

    // ready held high across frame end restarts on the edge after busy falls
    task automatic test_back_to_back();
        int exp;
        run_frame(1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        n_checks++; if (r_cyc !== 176) $display("FAIL b2b_first_cycles: got %0d want 176", r_cyc); else n_pass++;
        for (int i = 0; i < r_nw && i < 16; i++) begin
            exp = model_px(a_img, 4, 4, i % 4, i / 4, 2);
            n_checks++;
            if (r_addr[i] !== i || r_data[i] !== exp)
                $display("FAIL b2b_max_px%0d: got addr %0d data %0d want addr %0d data %0d", i, r_addr[i], r_data[i], i, exp);
            else n_pass++;
        end
        a_mode = 2'd1;
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b1) $display("FAIL b2b_restart: got busy %b want 1", a_busy); else n_pass++;
        run_frame(1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (r_cyc !== 176) $display("FAIL b2b_second_cycles: got %0d want 176", r_cyc); else n_pass++;
        n_checks++; if (r_nw !== 16) $display("FAIL b2b_second_writes: got %0d want 16", r_nw); else n_pass++;
        for (int i = 0; i < r_nw && i < 16; i++) begin
            exp = model_px(a_img, 4, 4, i % 4, i / 4, 1);
            n_checks++;
            if (r_addr[i] !== i || r_data[i] !== exp)
                $display("FAIL b2b_min_px%0d: got addr %0d data %0d want addr %0d data %0d", i, r_addr[i], r_data[i], i, exp);
            else n_pass++;
        end
    endtask

    // ready pulses during a frame must neither restart nor stretch it
    task automatic test_ready_ignored();
        int bad;
        run_frame(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (r_cyc !== 176) $display("FAIL pulse_cycles: got %0d want 176", r_cyc); else n_pass++;
        n_checks++; if (r_nw !== 16) $display("FAIL pulse_writes: got %0d want 16", r_nw); else n_pass++;
        n_checks++;
        if (r_addr[15] !== 15 || r_data[15] !== model_px(a_img, 4, 4, 3, 3, 0))
            $display("FAIL pulse_last_px: got addr %0d data %0d", r_addr[15], r_data[15]);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            if (a_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad !== 0) $display("FAIL pulse_no_restart: got %0d busy cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nw;
        int bad;
        int seen;
        int exp;
        a_mode = 2'd0; a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        nw = 0;
        // negedge c lies in pixel (c-1)/11, slot (c-1)%11; c=81 is pixel 7 FETCH k=3
        for (int c = 1; c < 81; c++) begin
            if (a_wen) nw++;
            @(negedge clk);
        end
        n_checks++; if (nw !== 7 || a_busy !== 1'b1) $display("FAIL midrst_pre: got writes %0d busy %b want 7 1", nw, a_busy); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL midrst_busy_async: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_wen !== 1'b0) $display("FAIL midrst_wen_async: got %b want 0", a_wen); else n_pass++;
        n_checks++; if (a_iaddr !== 4'd0) $display("FAIL midrst_iaddr_async: got %0d want 0", a_iaddr); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (a_busy !== 1'b0 || a_wen !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad !== 0) $display("FAIL midrst_stays_idle: got %0d active cycles want 0", bad); else n_pass++;
        run_frame(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (r_cyc !== 176 || r_nw !== 16) $display("FAIL midrst_rerun: got cycles %0d writes %0d want 176 16", r_cyc, r_nw); else n_pass++;
        for (int i = 0; i < r_nw && i < 16; i++) begin
            exp = model_px(a_img, 4, 4, i % 4, i / 4, 0);
            n_checks++;
            if (r_addr[i] !== i || r_data[i] !== exp)
                $display("FAIL midrst_px%0d: got addr %0d data %0d want addr %0d data %0d", i, r_addr[i], r_data[i], i, exp);
            else n_pass++;
        end
        // Reset during the second write: strobe and result drop without an edge
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 60 && seen < 2; c++) begin
            @(negedge clk);
            if (a_wen) seen++;
        end
        n_checks++;
        if (seen !== 2 || a_addr !== 4'd1 || a_data_wr !== 8'd16)
            $display("FAIL wrrst_pre: got seen %0d addr %0d data %0d want 2 1 16", seen, a_addr, a_data_wr);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (a_wen !== 1'b0 || a_addr !== 4'd0 || a_data_wr !== 8'd0)
            $display("FAIL wrrst_async: got wen %b addr %0d data %0d want 0 0 0", a_wen, a_addr, a_data_wr);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_a();
        logic [1:0] m;
        int exp;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) a_img[i] = int'($urandom_range(255, 0));
            m = 2'($urandom_range(3, 0));
            run_frame(1'b0, m, 1'b0, 1'b0, 1'b0);
            n_checks++; if (r_nw !== 16) $display("FAIL rnd_a%0d_writes: got %0d want 16", f, r_nw); else n_pass++;
            for (int i = 0; i < r_nw && i < 16; i++) begin
                exp = model_px(a_img, 4, 4, i % 4, i / 4, int'(m));
                n_checks++;
                if (r_addr[i] !== i || r_data[i] !== exp)
                    $display("FAIL rnd_a%0d_m%0d_px%0d: got addr %0d data %0d want addr %0d data %0d", f, m, i, r_addr[i], r_data[i], i, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_b_modes();
        int exp;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 16; i++) b_img[i] = int'($urandom_range(4095, 0));
            run_frame(1'b1, 2'(m), 1'b0, 1'b0, 1'b0);
            n_checks++; if (r_cyc !== 165) $display("FAIL b_m%0d_cycles: got %0d want 165", m, r_cyc); else n_pass++;
            n_checks++; if (r_nw !== 15) $display("FAIL b_m%0d_writes: got %0d want 15", m, r_nw); else n_pass++;
            n_checks++; if (r_iamax > 14) $display("FAIL b_m%0d_iaddr_max: got %0d want <=14", m, r_iamax); else n_pass++;
            n_checks++; if (r_consec !== 0) $display("FAIL b_m%0d_wen_consecutive: got %0d want 0", m, r_consec); else n_pass++;
            for (int i = 0; i < r_nw && i < 15; i++) begin
                exp = model_px(b_img, 5, 3, i % 5, i / 5, m);
                n_checks++;
                if (r_addr[i] !== i || r_data[i] !== exp)
                    $display("FAIL b_m%0d_px%0d: got addr %0d data %0h want addr %0d data %0h", m, i, r_addr[i], r_data[i], i, exp);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        a_mode   = 2'd0;
        b_mode   = 2'd0;
        for (int i = 0; i < 16; i++) begin
            a_img[i] = 0;
            b_img[i] = 0;
        end
        test_reset();
        test_const_image();
        test_ramp();
        test_back_to_back();
        test_ready_ignored();
        test_reset_mid();
        test_random_a();
        test_b_modes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mfe_param.md
# mfe_param

Parametrised median-filter engine, successor to the fixed 128x128, 8-bit MFE. It reads a raster image from the pattern ROM port, applies a 3x3 zero-padded window filter per pixel and writes the result to the result RAM port. The filter is selectable at start as median, minimum or maximum. It sits between the image source and the result memory, and the ready/busy handshake and memory-port protocol stay pin-compatible with MFE.

## Interface
- IMG_W, default 128: image width in pixels, ≥2.
- IMG_H, default 128: image height in pixels, ≥2.
- DW, default 8: pixel width in bits.
- AW, default $clog2(IMG_W*IMG_H): address width.
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- ready  in  1: start request, sampled only while busy=0.
- mode  in  2: filter select, latched on start. 0=median, 1=min, 2=max, 3=median.
- busy  out  1: high while a frame is being processed.
- iaddr  out  AW: source pixel address, row-major (y*IMG_W+x).
- idata  in  DW: source pixel; valid at the rising edge that ends the cycle iaddr is presented.
- wen  out  1: result write strobe (1 = write; 0 = read/idle).
- addr  out  AW: result address.
- data_wr  out  DW: result pixel.
- data_rd  in  DW: reserved, ignored.

## Operation
- States:
  - IDLE: reset state.
  - FETCH: k=0..8, 9 cycles.
  - LAST: 1 cycle.
  - WRITE: 1 cycle.
- IDLE → FETCH on a rising edge with ready=1 and busy=0. On that edge: busy←1, x←0, y←0, k←0, mode latched.
- FETCH window slot k maps to dy=k/3−1, dx=k%3−1. iaddr = (y+dy)*IMG_W+(x+dx).
- Padding: if y+dy or x+dx falls outside the image, iaddr is the clamped in-image address and the sample is forced to 0 (idata ignored).
- Sorter: a 9-entry ascending register array, cleared on entry to FETCH k=0. Each sample is inserted by parallel compare-and-shift in the cycle after its address (FETCH k=1..8 and LAST insert samples 0..8).
- Result by mode:
  - median: sorted[4]
  - min: sorted[0]
  - max: sorted[8]
  - Ties need no special handling; the multiset is what matters.
- WRITE: wen=1, addr=y*IMG_W+x, data_wr=result, for exactly one cycle.
- After WRITE:
  - x advances; at x=IMG_W−1 it wraps to 0 and y increments.
  - At the last pixel (IMG_W−1, IMG_H−1) the FSM goes to IDLE with busy←0.
  - Otherwise it goes to FETCH k=0.
- ready while busy=1 is ignored. Holding ready high in IDLE after a frame starts a new frame.
- All arithmetic is unsigned DW-bit with no rounding. Addresses are AW bits; no address ever exceeds IMG_W*IMG_H−1.

## Timing
- Reset values: busy=0, wen=0, iaddr=0, addr=0, data_wr=0, state=IDLE, sorter cleared.
- Start: ready sampled at edge E gives busy=1 and iaddr=slot0 of pixel 0 from E onward.
- Per pixel: exactly 11 cycles (9 FETCH + LAST + WRITE), independent of padding.
- Frame: busy stays high for exactly 11*IMG_W*IMG_H cycles. busy falls on the edge that ends the final WRITE.
- wen is high only in WRITE. It is never high in two consecutive cycles.
- Reset mid-frame, asserted asynchronously: all outputs go to their reset values immediately (wen=0 without waiting for an edge). A new frame needs a fresh ready.
- The sample for slot k is captured at the edge ending FETCH k, so idata has one cycle of read latency.

## Test plan
- IMG_W=IMG_H=4, DW=8, all pixels 0x55, mode=0:
  - interior (1,1),(2,1),(1,2),(2,2) → 0x55
  - edges (6 real) → 0x55
  - corners (4 real, 5 zeros) → 0x00
- Same image, mode=1 → interior 0x55, every border pixel 0x00. Same image, mode=2 → all 16 outputs 0x55.
- 4x4 image, pixel(i)=i*16, mode=0 → addr 5 writes median{0,16,32,64,80,96,128,144,160}=80; full image matches the software model. busy is high exactly 176 cycles, wen pulses 16 times at addr 0..15 in order.
- Handshake: hold ready=1 across frame end → second frame starts on the edge after busy falls. Pulse ready while busy=1 → no restart and no change to the cycle count.
- Assert reset during FETCH of pixel 7 → wen=0 and busy=0 immediately, no further writes. A new ready reruns the whole frame correctly.
- DW=12, IMG_W=5, IMG_H=3, random data, all three modes → bit-exact against the model. 15 writes per frame, 165 busy cycles, iaddr always ≤14.
